// File: rtl/mac_feeder.sv
// mac_feeder: walks the filter and ifmap scratchpads into 1-D convolution windows, drives the
//   MAC pipeline and collects each window's psum in a 2-entry output FIFO.
// Latency: first tap the cycle after an accepted start; a window's result is at out_valid
//   4 cycles after its last tap, plus one cycle for every stalled cycle.
// Backpressure: stall = FIFO full && !out_ready freezes the sequencer and the pipeline; no result is dropped.
//
// Ports (top): clk, rst (async, active-low); job request start/filt_len/num_win/stride; busy;
//   scratchpad fetch spad_rd_en/ifmap_addr/filt_addr; pipeline control run/clr_pipe/done_psum_req/stall;
//   pipeline result done_psum/psum_in; result stream out_data/out_valid/out_ready; done pulse.
// Build option: define MAC_FEEDER_RELU_EN to store negative psums as zero; undefined stores them as received.

// Generic FIFO: push and pop may coincide at any occupancy. DEPTH must be a power of two.
module mac_feeder_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module mac_feeder #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] filt_len,
  input  logic [ADDR_W-1:0] num_win,
  input  logic [1:0]        stride,
  output logic              busy,
  output logic              spad_rd_en,
  output logic [ADDR_W-1:0] ifmap_addr,
  output logic [ADDR_W-1:0] filt_addr,
  output logic              run,
  output logic              clr_pipe,
  output logic              done_psum_req,
  output logic              stall,
  input  logic              done_psum,
  input  logic [WIDTH-1:0]  psum_in,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);
  localparam int FIFO_DEPTH = 2;
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] nwin_q;
  logic [1:0]        stride_q;
  logic [ADDR_W-1:0] k_q;
  logic [ADDR_W-1:0] w_q;
  logic [ADDR_W-1:0] base_q;     // w_q*stride, kept incrementally
  logic [ADDR_W:0]   cap_cnt;
  logic              dpr_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_cnt;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  push_dat;
  logic              last_tap;
  logic              drain_ok;

  assign stall     = fifo_full && !out_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A strobe outside a job cannot belong to anything we issued, so it is not captured.
  assign push      = done_psum && !stall && (state != IDLE);

`ifdef MAC_FEEDER_RELU_EN
  assign push_dat = psum_in[WIDTH-1] ? '0 : psum_in;
`else
  assign push_dat = psum_in;
`endif

  assign last_tap      = (k_q == len_q - ADDR_W'(1));
  assign run           = (state == ISSUE) && !stall;
  assign spad_rd_en    = run;
  assign clr_pipe      = run && last_tap;
  assign filt_addr     = k_q;
  assign ifmap_addr    = base_q + k_q;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign done_psum_req = dpr_q;

  // Leave DRAIN on the edge that empties the FIFO so done follows the last pop by one cycle.
  assign drain_ok = (cap_cnt == {1'b0, nwin_q}) && !push && (fifo_cnt == FCW'(pop));

  mac_feeder_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      nwin_q   <= '0;
      stride_q <= '0;
      k_q      <= '0;
      w_q      <= '0;
      base_q   <= '0;
      cap_cnt  <= '0;
      dpr_q    <= 1'b0;
    end else if (!stall) begin
      if (push) cap_cnt <= cap_cnt + (ADDR_W+1)'(1);
      dpr_q <= clr_pipe;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= filt_len;
            nwin_q   <= num_win;
            stride_q <= stride;
            k_q      <= '0;
            w_q      <= '0;
            base_q   <= '0;
            cap_cnt  <= '0;
            state    <= (filt_len == '0 || num_win == '0) ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          if (last_tap) begin
            k_q <= '0;
            if (w_q == nwin_q - ADDR_W'(1)) begin
              state <= DRAIN;
            end else begin
              w_q    <= w_q + ADDR_W'(1);
              base_q <= base_q + {{(ADDR_W-2){1'b0}}, stride_q};
            end
          end else begin
            k_q <= k_q + ADDR_W'(1);
          end
        end
        DRAIN: if (drain_ok) state <= FIN;
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;
  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] filt_len;
  logic [AW-1:0] num_win;
  logic [1:0]    stride;
  logic          busy;
  logic          spad_rd_en;
  logic [AW-1:0] ifmap_addr;
  logic [AW-1:0] filt_addr;
  logic          run;
  logic          clr_pipe;
  logic          done_psum_req;
  logic          stall;
  logic          done_psum;
  logic [W-1:0]  psum_in;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int pend;
  bit bp_seen;

  int exp_q[$];
  int tap_addr_q[$];
  bit tap_clr_q[$];
  int tap_cyc_q[$];

  always #5 clk = ~clk;

  mac_feeder dut (
    .clk(clk), .rst(rst), .start(start), .filt_len(filt_len), .num_win(num_win), .stride(stride),
    .busy(busy), .spad_rd_en(spad_rd_en), .ifmap_addr(ifmap_addr), .filt_addr(filt_addr),
    .run(run), .clr_pipe(clr_pipe), .done_psum_req(done_psum_req), .stall(stall),
    .done_psum(done_psum), .psum_in(psum_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  // Scratchpads and a behavioural MAC pipeline: operands arrive one cycle after run,
  // the result leaves two cycles after the cycle that consumed the last tap.
  logic signed [W-1:0] filt_mem  [32];
  logic signed [W-1:0] ifmap_mem [32];
  logic signed [W-1:0] filt_q, ifm_q, acc, p1, p2, mac_sum;
  logic                run_d, clr_d, p1_vld, p2_vld;

  assign mac_sum   = acc + filt_q * ifm_q;
  assign done_psum = p2_vld;
  assign psum_in   = p2;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= '0; ifm_q <= '0; acc <= '0; p1 <= '0; p2 <= '0;
      run_d <= 1'b0; clr_d <= 1'b0; p1_vld <= 1'b0; p2_vld <= 1'b0;
    end else if (!stall) begin
      if (spad_rd_en) begin
        filt_q <= filt_mem[filt_addr];
        ifm_q  <= ifmap_mem[ifmap_addr];
      end
      run_d <= run;
      clr_d <= clr_pipe;
      if (run_d) begin
        if (clr_d) begin
          acc <= '0;
          p1  <= mac_sum;
        end else begin
          acc <= mac_sum;
        end
      end
      p1_vld <= run_d && clr_d;
      p2_vld <= p1_vld;
      p2     <= p1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Results accepted by the DUT but not yet popped.
  always @(posedge clk or negedge rst) begin
    if (!rst) pend <= 0;
    else pend <= pend + int'(done_psum && !stall && busy) - int'(out_valid && out_ready);
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, tap log, and cycle-level protocol checks.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data_unexpected: got %0d expected no result", $signed(out_data));
        end else begin
          chk("out_data", $signed(out_data), exp_q.pop_front());
        end
        last_pop_cyc = cyc;
      end
      if (run) begin
        tap_addr_q.push_back(int'(ifmap_addr));
        tap_clr_q.push_back(clr_pipe);
        tap_cyc_q.push_back(cyc);
      end
      if (done_psum_req || clr_d) chk("done_psum_req_timing", done_psum_req, clr_d);
      if (stall || (pend == 2 && !out_ready)) chk("stall_vs_occupancy", stall, (pend == 2 && !out_ready));
      if (out_valid || pend != 0) chk("out_valid_vs_pending", out_valid, (pend != 0));
    end
  end

  task automatic do_start(input int fl, input int nw, input int st);
    tap_addr_q.delete();
    tap_clr_q.delete();
    tap_cyc_q.delete();
    @(posedge clk); #1;
    filt_len = AW'(fl);
    num_win  = AW'(nw);
    stride   = 2'(st);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic first_run_chk(input string tag);
    @(negedge clk);
    chk({tag, "_first_run"}, run, 1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done pulse expected one within 300 cycles", tag);
    end else begin
      chk({tag, "_done_after_pop"}, cyc - last_pop_cyc, 1);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
      @(negedge clk);
      chk({tag, "_done_width"}, done, 0);
    end
  endtask

  task automatic check_taps(input string tag, input int n, input int clr_mask);
    int m = 0;
    chk({tag, "_tap_count"}, tap_cyc_q.size(), n);
    if (tap_cyc_q.size() > 0)
      chk({tag, "_taps_back_to_back"}, tap_cyc_q[$] - tap_cyc_q[0] + 1, n);
    foreach (tap_clr_q[i]) if (tap_clr_q[i]) m |= (1 << i);
    chk({tag, "_clr_mask"}, m, clr_mask);
  endtask

  task automatic load_default();
    for (int i = 0; i < 32; i++) begin
      filt_mem[i]  = '0;
      ifmap_mem[i] = (i < 8) ? W'(i + 1) : '0;
    end
  endtask

  initial begin
    int busy_cnt, run_cnt, done_idx;
    bit found;
    rst = 1'b0; start = 1'b0; filt_len = '0; num_win = '0; stride = '0; out_ready = 1'b1;
    load_default();
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero",
        ({busy, run, spad_rd_en, clr_pipe, done_psum_req, stall, out_valid, done,
          ifmap_addr, filt_addr, out_data} === '0) ? 0 : 1, 0);
    rst = 1'b1;

    // Basic job: windows [1,2,3]*[1,2,3]=14 and [1,2,3]*[2,3,4]=20.
    filt_mem[0] = 1; filt_mem[1] = 2; filt_mem[2] = 3;
    exp_q.push_back(14); exp_q.push_back(20);
    do_start(3, 2, 1);
    first_run_chk("basic");
    wait_done("basic");
    check_taps("basic", 6, 6'b100100);

    // Stride 2: ifmap addresses 0..5, sums 1+2, 3+4, 5+6.
    filt_mem[0] = 1; filt_mem[1] = 1; filt_mem[2] = 0;
    exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(11);
    do_start(2, 3, 2);
    first_run_chk("stride");
    wait_done("stride");
    check_taps("stride", 6, 6'b101010);
    for (int i = 0; i < 6; i++)
      chk("stride_ifmap_addr", (i < tap_addr_q.size()) ? tap_addr_q[i] : -1, i);

    // Backpressure: single-tap windows, consumer held off until the pipeline is frozen.
    filt_mem[0] = 2; filt_mem[1] = 0;
    exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(8);
    out_ready = 1'b0;
    bp_seen = 1'b0;
    fork
      begin
        do_start(1, 4, 1);
        wait_done("bp");
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (stall) begin
            bp_seen = 1'b1;
            break;
          end
        end
        chk("bp_stall_rise", bp_seen, 1);
        chk("bp_pending_at_stall", pend, 2);
        chk("bp_third_at_done_psum", done_psum, 1);
        repeat (3) @(negedge clk);
        chk("bp_stall_held", stall, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join

    // Zero-length jobs finish without issuing taps.
    do_start(0, 2, 1);
    busy_cnt = 0; run_cnt = 0; done_idx = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      run_cnt  += int'(run);
      if (done && done_idx == 0) done_idx = i;
    end
    chk("zero_len_busy_cycles", busy_cnt, 1);
    chk("zero_len_runs", run_cnt, 0);
    chk("zero_len_done_seen_early", (done_idx >= 1 && done_idx <= 2) ? 1 : 0, 1);
    do_start(2, 0, 1);
    busy_cnt = 0; run_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      run_cnt  += int'(run);
    end
    chk("zero_win_busy_cycles", busy_cnt, 1);
    chk("zero_win_runs", run_cnt, 0);

    // Reset during window 1, then a clean rerun.
    filt_mem[0] = 1; filt_mem[1] = 2; filt_mem[2] = 3;
    exp_q.push_back(14); exp_q.push_back(20); exp_q.push_back(26);
    do_start(3, 3, 1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (clr_pipe) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_reached_win1", found, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_outputs_zero",
        ({busy, run, spad_rd_en, clr_pipe, done_psum_req, stall, out_valid, done,
          ifmap_addr, filt_addr, out_data} === '0) ? 0 : 1, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(14); exp_q.push_back(20);
    do_start(3, 2, 1);
    first_run_chk("rerun");
    wait_done("rerun");

    // Negative psum handling.
    filt_mem[0] = -16'sd1;
    ifmap_mem[0] = 16'sd5;
    ifmap_mem[1] = -16'sd3;
`ifdef MAC_FEEDER_RELU_EN
    exp_q.push_back(0);
`else
    exp_q.push_back(-5);
`endif
    exp_q.push_back(3);
    do_start(1, 2, 1);
    first_run_chk("relu");
    wait_done("relu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
